// File: rtl/mio_spi_target.sv
// mio_spi_target: SPI mode-0 target that oversamples the bus in the clk domain and moves words to/from valid/ready ports
module mio_spi_target #(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t            r_state, w_state_nx;
  logic [2:0]        r_sclk_q, r_cs_q, r_mosi_q;
  logic              r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall;
  logic [CW-1:0]     r_cnt;
  logic              r_reload;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr;
  logic              w_load, w_rise, w_fall;
  // Two sync flops plus history per pin, then registered edge pulses; cs_n resets low so a frame selected across reset is not taken as a fall
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sclk_q    <= '0;
      r_cs_q      <= '0;
      r_mosi_q    <= '0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
    end else begin
      r_sclk_q    <= {r_sclk_q[1:0], sclk};
      r_cs_q      <= {r_cs_q[1:0], cs_n};
      r_mosi_q    <= {r_mosi_q[1:0], mosi};
      r_sclk_rise <= r_sclk_q[1] & ~r_sclk_q[2];
      r_sclk_fall <= ~r_sclk_q[1] & r_sclk_q[2];
      r_cs_rise   <= r_cs_q[1] & ~r_cs_q[2];
      r_cs_fall   <= ~r_cs_q[1] & r_cs_q[2];
    end
  // Frame state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  // Next state and event decode; a cs_n rise wins over any sclk edge in the same cycle
  always_comb begin
    w_state_nx  = r_state;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_load      = 1'b0;
    frame_abort = 1'b0;
    if (r_state == S_IDLE) begin
      w_state_nx = r_cs_fall ? S_ACTIVE : S_IDLE;
      w_load     = r_cs_fall;
    end else if (r_cs_rise) begin
      w_state_nx  = S_IDLE;
      frame_abort = r_cnt != '0;
    end else begin
      w_rise = r_sclk_rise;
      w_fall = r_sclk_fall;
      w_load = r_sclk_fall & r_reload;
    end
  end
  assign tx_ready    = w_load;
  assign tx_underrun = w_load & ~tx_valid;
  assign miso_oe     = r_state == S_ACTIVE;
  assign miso        = miso_oe ? r_tx_sr[DATA_W-1] : IDLE_BIT;
  // Shift registers, bit counter and word completion; leaving or staying in IDLE discards any partial word
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt    <= '0;
      r_reload <= 1'b0;
      r_tx_sr  <= {DATA_W{IDLE_BIT}};
      r_rx_sr  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (w_load) begin
        r_tx_sr  <= tx_valid ? tx_data : {DATA_W{IDLE_BIT}};
        r_reload <= 1'b0;
      end else if (w_fall) r_tx_sr <= {r_tx_sr[DATA_W-2:0], IDLE_BIT};
      if (w_rise) begin
        r_rx_sr <= {r_rx_sr[DATA_W-2:0], r_mosi_q[2]};
        r_cnt   <= r_cnt + 1'b1;
        if (r_cnt == CW'(DATA_W - 1)) begin
          rx_data  <= {r_rx_sr[DATA_W-2:0], r_mosi_q[2]};
          rx_valid <= 1'b1;
          r_cnt    <= '0;
          r_reload <= 1'b1;
        end
      end
      if (w_state_nx == S_IDLE) begin
        r_cnt    <= '0;
        r_reload <= 1'b0;
      end
    end
endmodule
